axi_lite_cmd_arbiter: RTL and testbench
=======================================

# axi_lite_cmd_arbiter

Two-requester command arbiter and AXI4-Lite master that shares one AXI4-Lite slave register port (e.g. the S00_AXI port of example_core_lite) between two local command sources. Each requester issues single-word read or write commands over a simple valid/ack handshake. The block grants requesters round-robin and runs exactly one AXI4-Lite transaction per grant. It returns the read data and response to the granted requester.

## Interface
- C_M_AXI_ADDR_WIDTH, 32: address width of the requester and AXI buses.
- C_M_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- ACLK  in  1  clock; all logic on its rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- REQ_VALID  in  2  per-requester command valid; bit i = requester i.
- REQ_WE  in  2  per-requester command type; 1 = write, 0 = read.
- REQ_ADDR  in  2*AW  requester i address at bits [i*AW +: AW].
- REQ_WDATA  in  2*DW  requester i write data at bits [i*DW +: DW].
- REQ_ACK  out  2  one-cycle completion pulse, one-hot to the granted requester.
- RSP_RDATA  out  DW  read data; valid only in the REQ_ACK cycle of a read.
- RSP_RESP  out  2  AXI response (BRESP or RRESP); valid in the REQ_ACK cycle.
- GRANT  out  2  one-hot owner of the current transaction; 0 when idle.
- BUSY  out  1  high in every state except IDLE.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master signals.
  - Widths follow the parameters.
  - AWPROT and ARPROT are tied to 3'b000.
  - WSTRB is tied to all ones.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - If any REQ_VALID bit is set, arbitrate.
  - Latch the winner's WE, ADDR and WDATA into internal registers.
  - Set GRANT to the winner.
  - Go to WADDR if WE = 1, otherwise to RADDR.
- Arbitration is round-robin using the last_grant register.
  - On a tie, the requester other than last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - last_grant updates in DONE.
- WADDR:
  - AWVALID and WVALID assert together on entry.
  - Each drops independently in the cycle after its own handshake (VALID&READY).
  - The state exits to WRESP once both handshakes have occurred, in either order or simultaneously.
- WRESP: BREADY = 1. On BVALID, capture BRESP into RSP_RESP and go to DONE.
- RADDR: ARVALID = 1 until ARREADY, then go to RDATA.
- RDATA: RREADY = 1. On RVALID, capture RDATA and RRESP and go to DONE.
- DONE:
  - REQ_ACK[grant] = 1 for this single cycle.
  - RSP_RDATA and RSP_RESP are held stable.
  - GRANT is cleared on exit.
  - Next state is IDLE.
- Requester rule: hold REQ_VALID and the command fields stable until REQ_ACK.
  - The fields are latched in IDLE, so later changes do not affect the transaction in flight.
  - A REQ_VALID still high after REQ_ACK is treated as a new command.
- AXI rules:
  - VALID, once asserted, is never withdrawn before its READY.
  - At most one outstanding transaction.
  - No combinational path from any READY to any VALID.
- Error responses (SLVERR/DECERR) are passed through in RSP_RESP. No retry is attempted.

## Timing
- Reset (ARESETN = 0 at a rising edge):
  - FSM goes to IDLE and last_grant to 1.
  - All AXI VALID and READY outputs, REQ_ACK, GRANT and BUSY go to 0.
  - RSP_RDATA and RSP_RESP go to 0.
  - AWADDR, ARADDR and WDATA go to 0.
- Reset mid-transaction: outputs drop to the reset values in the next cycle. No REQ_ACK is issued for the aborted command.
- Minimum latency, with the slave ready immediately:
  - Write: VALID sampled in IDLE at cycle 0; AW/W handshake at cycle 1; BVALID accepted at cycle 2; REQ_ACK at cycle 3.
  - Read: AR handshake at cycle 1, R accepted at cycle 2, REQ_ACK at cycle 3.
- Back-to-back: the earliest next arbitration is in the IDLE cycle after DONE. Minimum command spacing is 4 cycles.
- Slave stalls extend WADDR, WRESP, RADDR or RDATA indefinitely. There is no timeout.

## Test plan
- Requester 0 writes 0x0101FFFF to address 0x0; the slave is always ready:
  - AWVALID and WVALID assert together one cycle after REQ_VALID is sampled.
  - REQ_ACK = 2'b01 at cycle 3 with RSP_RESP = 00.
  - Requester 1 then reads 0x0 and gets REQ_ACK = 2'b10 with RSP_RDATA = 0x0101FFFF.
- Both requesters are held valid continuously, writing 0xABCD0001 to 0x4 (req 0) and 0xDEAD0011 to 0x8 (req 1):
  - Grants alternate 0, 1, 0, 1, starting with 0 after reset.
  - Readback of 0x4 returns 0xABCD0001 and readback of 0x8 returns 0xDEAD0011.
- Slave holds AWREADY low for 3 cycles while WREADY is immediate:
  - WVALID drops after 1 cycle, AWVALID is held 4 cycles.
  - WRESP is entered only after the AW handshake; REQ_ACK arrives 3 cycles later than in the unstalled case.
- Slave returns RRESP = 2'b10 on a read of 0xC: RSP_RESP = 10 in the ACK cycle, and the FSM returns to IDLE.
- ARESETN is driven low for 1 cycle while in WRESP with BVALID still low:
  - No REQ_ACK is issued; BREADY, GRANT and BUSY are 0 the next cycle.
  - A subsequent write of 0xBEEF0011 completes normally.
- Only requester 1 is valid, for 3 consecutive commands: all three are granted to 1, each with REQ_ACK spaced 4 cycles apart.

Source files
------------

// File: rtl/axi_lite_cmd_arbiter_if.sv
// AXI4-Lite bus bundle between the command arbiter (master) and a register slave.
interface axi_lite_cmd_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter for two single-word command sources sharing one AXI4-Lite
// slave; one AXI transaction per grant, result returned with a one-cycle ack.
module axi_lite_cmd_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            i_aclk,
    input  logic                            i_aresetn,
    input  logic [1:0]                      i_req_valid,
    input  logic [1:0]                      i_req_we,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0] i_req_wdata,
    output logic [1:0]                      o_req_ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                      o_rsp_resp,
    output logic [1:0]                      o_grant,
    output logic                            o_busy,
    axi_lite_cmd_arbiter_if.master          m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_last_grant;
    logic [1:0]    r_grant;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_arvalid;
    logic [DW-1:0] r_rsp_rdata;
    logic [1:0]    r_rsp_resp;

    logic [AW-1:0] w_addr_arr  [2];
    logic [DW-1:0] w_wdata_arr [2];
    logic          w_winner;
    logic          w_sel_we;
    logic          w_aw_ok;
    logic          w_w_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_addr_arr[gi]  = i_req_addr[gi*AW +: AW];
            assign w_wdata_arr[gi] = i_req_wdata[gi*DW +: DW];
            assign o_req_ack[gi]   = (r_state == S_DONE) && r_grant[gi];
        end
    endgenerate

    // On a tie the requester that did not own the previous transaction wins.
    assign w_winner = (&i_req_valid) ? ~r_last_grant : i_req_valid[1];
    assign w_sel_we = i_req_we[w_winner];

    // A channel counts as done once its VALID has already dropped or is handshaking now.
    assign w_aw_ok = !r_awvalid || m_axi.awready;
    assign w_w_ok  = !r_wvalid  || m_axi.wready;

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (|i_req_valid) w_state_next = w_sel_we ? S_WADDR : S_RADDR;
            S_WADDR: if (w_aw_ok && w_w_ok) w_state_next = S_WRESP;
            S_WRESP: if (m_axi.bvalid) w_state_next = S_DONE;
            S_RADDR: if (m_axi.arready) w_state_next = S_RDATA;
            S_RDATA: if (m_axi.rvalid) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_last_grant <= 1'b1;
            r_grant      <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_resp   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|i_req_valid) begin
                        r_grant   <= w_winner ? 2'b10 : 2'b01;
                        r_addr    <= w_addr_arr[w_winner];
                        r_wdata   <= w_wdata_arr[w_winner];
                        r_awvalid <= w_sel_we;
                        r_wvalid  <= w_sel_we;
                        r_arvalid <= !w_sel_we;
                    end
                end
                S_WADDR: begin
                    if (m_axi.awready) r_awvalid <= 1'b0;
                    if (m_axi.wready)  r_wvalid  <= 1'b0;
                end
                S_WRESP: begin
                    if (m_axi.bvalid) r_rsp_resp <= m_axi.bresp;
                end
                S_RADDR: begin
                    if (m_axi.arready) r_arvalid <= 1'b0;
                end
                S_RDATA: begin
                    if (m_axi.rvalid) begin
                        r_rsp_rdata <= m_axi.rdata;
                        r_rsp_resp  <= m_axi.rresp;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_grant[1];
                    r_grant      <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign m_axi.awaddr  = r_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = (r_state == S_WRESP);
    assign m_axi.araddr  = r_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = (r_state == S_RDATA);

    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_resp  = r_rsp_resp;
    assign o_grant     = r_grant;
    assign o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Bench for axi_lite_cmd_arbiter: stallable AXI4-Lite slave with a register file,
// directed scenarios plus randomized two-requester traffic against a command-level model.
module tb_axi_lite_cmd_arbiter;
    logic        clk;
    logic        aresetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  ack;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    axi_lite_cmd_arbiter_if #(.AW(32), .DW(32)) bus ();

    axi_lite_cmd_arbiter #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
        .i_aclk      (clk),
        .i_aresetn   (aresetn),
        .i_req_valid (req_valid),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_req_ack   (ack),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_resp  (rsp_resp),
        .o_grant     (grant),
        .o_busy      (busy),
        .m_axi       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int aw_stall = 0, w_stall = 0, ar_stall = 0, b_delay = 0, r_delay = 0;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, ar_got;
    logic [31:0] aw_a, w_d, ar_a;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_stall);
    assign bus.wready  = bus.wvalid  && (w_cnt  >= w_stall);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_stall);

    wire hs_aw = bus.awvalid && bus.awready;
    wire hs_w  = bus.wvalid  && bus.wready;
    wire hs_ar = bus.arvalid && bus.arready;
    wire s_aw_ok = aw_got || hs_aw;
    wire s_w_ok  = w_got  || hs_w;
    wire s_ar_ok = ar_got || hs_ar;
    wire [31:0] s_aw_a = aw_got ? aw_a : bus.awaddr;
    wire [31:0] s_w_d  = w_got  ? w_d  : bus.wdata;
    wire [31:0] s_ar_a = ar_got ? ar_a : bus.araddr;

    always @(posedge clk) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_a <= '0; w_d <= '0; ar_a <= '0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
        end else begin
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid  && !bus.wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (s_aw_ok && s_w_ok && !bus.bvalid) begin
                if (b_cnt >= b_delay) begin
                    mem[s_aw_a[5:2]] <= s_w_d;
                    bus.bvalid <= 1'b1; bus.bresp <= 2'b00;
                    aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                end else begin
                    b_cnt <= b_cnt + 1;
                    aw_got <= 1'b1; aw_a <= s_aw_a; w_got <= 1'b1; w_d <= s_w_d;
                end
            end else begin
                if (hs_aw) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
                if (hs_w)  begin w_got  <= 1'b1; w_d  <= bus.wdata;  end
            end
            if (s_ar_ok && !bus.rvalid) begin
                if (r_cnt >= r_delay) begin
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= mem[s_ar_a[5:2]];
                    bus.rresp  <= (s_ar_a == 32'hC) ? 2'b10 : 2'b00;
                    ar_got <= 1'b0; r_cnt <= 0;
                end else begin
                    r_cnt <= r_cnt + 1; ar_got <= 1'b1; ar_a <= s_ar_a;
                end
            end
        end
    end

    // ---------------- requester driver ----------------
    logic       tr_awv [64];
    logic       tr_wv  [64];
    logic       tr_brdy[64];
    logic       tr_arv [64];
    logic       tr_busy[64];
    logic [1:0] tr_grant[64];

    task automatic do_cmd(input int r, input bit we, input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [1:0] a, output logic [1:0] resp,
                          output logic [31:0] rdata);
        int n;
        bit got;
        req_valid[r] = 1'b1;
        req_we[r] = we;
        req_addr[r*32 +: 32] = addr;
        req_wdata[r*32 +: 32] = data;
        n = 0; got = 0; a = 2'b00; resp = 2'bxx; rdata = 'x;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            tr_awv[n] = bus.awvalid; tr_wv[n] = bus.wvalid; tr_brdy[n] = bus.bready;
            tr_arv[n] = bus.arvalid; tr_busy[n] = busy; tr_grant[n] = grant;
            if (ack != 2'b00) begin
                got = 1; a = ack; resp = rsp_resp; rdata = rsp_rdata;
            end
        end
        req_valid[r] = 1'b0;
        lat = got ? n : -1;
        if (!got) begin
            checks++; errors++;
            $display("FAIL cmd_timeout req%0d: no ack after %0d cycles, required an ack", r, n);
        end
        $display("txn req%0d %s addr=%h wdata=%h ack=%b resp=%b rdata=%h lat=%0d",
                 r, we ? "WR" : "RD", addr, data, a, resp, rdata, lat);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0; req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b need 00", ack); end
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL reset_grant_busy: got %b/%b need 00/0", grant, busy); end
        checks++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
            errors++; $display("FAIL reset_handshake: got %b need 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %h/%b need 0/00", rsp_rdata, rsp_resp); end
        checks++; if (bus.awaddr !== 32'h0 || bus.araddr !== 32'h0 || bus.wdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus: got aw=%h ar=%h wd=%h need 0", bus.awaddr, bus.araddr, bus.wdata); end
        checks++; if (bus.wstrb !== 4'hF || bus.awprot !== 3'b000 || bus.arprot !== 3'b000) begin
            errors++; $display("FAIL ties: got wstrb=%h awprot=%b arprot=%b need f/000/000", bus.wstrb, bus.awprot, bus.arprot); end
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [1:0] a, resp; logic [31:0] rd;
        do_cmd(0, 1'b1, 32'h0, 32'h0101FFFF, lat, a, resp, rd);
        ref_mem[0] = 32'h0101FFFF;
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d need 3", lat); end
        checks++; if (a !== 2'b01 || resp !== 2'b00) begin errors++; $display("FAIL wr_ack: got %b/%b need 01/00", a, resp); end
        checks++; if (tr_awv[1] !== 1'b1 || tr_wv[1] !== 1'b1 || tr_awv[2] !== 1'b0 || tr_wv[2] !== 1'b0) begin
            errors++; $display("FAIL wr_valids: got aw=%b%b w=%b%b need 10/10", tr_awv[1], tr_awv[2], tr_wv[1], tr_wv[2]); end
        checks++; if (tr_grant[1] !== 2'b01 || tr_busy[1] !== 1'b1) begin errors++; $display("FAIL wr_grant: got %b/%b need 01/1", tr_grant[1], tr_busy[1]); end
        checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL idle_after_done: got %b/%b need 0/00", busy, grant); end
        do_cmd(1, 1'b0, 32'h0, 32'h0, lat, a, resp, rd);
        checks++; if (a !== 2'b10 || rd !== ref_mem[0] || lat !== 3) begin
            errors++; $display("FAIL rd_basic: got ack=%b rdata=%h lat=%0d need 10 %h 3", a, rd, lat, ref_mem[0]); end
        checks++; if (tr_arv[1] !== 1'b1 || tr_arv[2] !== 1'b0) begin errors++; $display("FAIL rd_arvalid: got %b%b need 10", tr_arv[1], tr_arv[2]); end
    endtask

    task automatic test_round_robin();
        int last, n, exp_w; bit got; int lat; logic [1:0] a, resp; logic [31:0] rd;
        apply_reset();
        last = 1;
        req_we = 2'b11;
        req_addr = {32'h8, 32'h4};
        req_wdata = {32'hDEAD0011, 32'hABCD0001};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0; got = 0;
            while (!got && n < 60) begin
                @(negedge clk); n++;
                got = (ack != 2'b00);
            end
            if (!got) begin
                checks++; errors++; $display("FAIL rr_timeout: no ack, need ack %0d", k); break;
            end
            exp_w = 1 - last;
            $display("txn rr%0d ack=%b spacing=%0d", k, ack, n);
            checks++; if (ack !== 2'(1 << exp_w)) begin errors++; $display("FAIL rr_grant%0d: got %b need %b", k, ack, 2'(1 << exp_w)); end
            checks++; if (n !== ((k == 0) ? 3 : 4)) begin errors++; $display("FAIL rr_spacing%0d: got %0d need %0d", k, n, (k == 0) ? 3 : 4); end
            ref_mem[exp_w == 0 ? 1 : 2] = (exp_w == 0) ? 32'hABCD0001 : 32'hDEAD0011;
            last = exp_w;
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        do_cmd(0, 1'b0, 32'h4, 32'h0, lat, a, resp, rd);
        checks++; if (rd !== 32'hABCD0001) begin errors++; $display("FAIL rr_readback4: got %h need abcd0001", rd); end
        do_cmd(1, 1'b0, 32'h8, 32'h0, lat, a, resp, rd);
        checks++; if (rd !== 32'hDEAD0011) begin errors++; $display("FAIL rr_readback8: got %h need dead0011", rd); end
    endtask

    task automatic test_aw_stall();
        int lat; logic [1:0] a, resp; logic [31:0] rd; logic [31:0] d;
        d = $urandom;
        aw_stall = 3;
        do_cmd(0, 1'b1, 32'h20, d, lat, a, resp, rd);
        aw_stall = 0;
        ref_mem[8] = d;
        checks++; if (lat !== 6 || a !== 2'b01) begin errors++; $display("FAIL stall_latency: got lat=%0d ack=%b need 6 01", lat, a); end
        checks++; if (tr_wv[1] !== 1'b1 || tr_wv[2] !== 1'b0) begin errors++; $display("FAIL stall_wvalid: got %b%b need 10", tr_wv[1], tr_wv[2]); end
        checks++; if ({tr_awv[1], tr_awv[2], tr_awv[3], tr_awv[4], tr_awv[5]} !== 5'b11110) begin
            errors++; $display("FAIL stall_awvalid: got %b need 11110", {tr_awv[1], tr_awv[2], tr_awv[3], tr_awv[4], tr_awv[5]}); end
        checks++; if (tr_brdy[4] !== 1'b0 || tr_brdy[5] !== 1'b1) begin errors++; $display("FAIL stall_wresp_entry: got %b%b need 01", tr_brdy[4], tr_brdy[5]); end
    endtask

    task automatic test_read_error();
        int lat; logic [1:0] a, resp; logic [31:0] rd;
        do_cmd(1, 1'b0, 32'hC, 32'h0, lat, a, resp, rd);
        checks++; if (resp !== 2'b10 || a !== 2'b10) begin errors++; $display("FAIL rd_slverr: got resp=%b ack=%b need 10 10", resp, a); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_err_idle: got busy=%b need 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n, lat; bit got, saw_ack; logic [1:0] a, resp; logic [31:0] rd;
        b_delay = 20;
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'h12345678;
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            got = bus.bready;
        end
        checks++; if (!got) begin errors++; $display("FAIL mid_reach_wresp: got bready=0 need 1"); end
        aresetn = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        checks++; if ({bus.bready, grant, busy, ack} !== 6'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got bready=%b grant=%b busy=%b ack=%b need 0", bus.bready, grant, busy, ack); end
        aresetn = 1'b1; b_delay = 0;
        saw_ack = 0;
        repeat (5) begin @(negedge clk); if (ack !== 2'b00) saw_ack = 1; end
        checks++; if (saw_ack) begin errors++; $display("FAIL mid_no_ack: got ack after reset need none"); end
        do_cmd(0, 1'b1, 32'h10, 32'hBEEF0011, lat, a, resp, rd);
        ref_mem[4] = 32'hBEEF0011;
        checks++; if (lat !== 3 || a !== 2'b01 || resp !== 2'b00) begin errors++; $display("FAIL mid_rewrite: got lat=%0d ack=%b resp=%b need 3 01 00", lat, a, resp); end
        do_cmd(1, 1'b0, 32'h10, 32'h0, lat, a, resp, rd);
        checks++; if (rd !== 32'hBEEF0011) begin errors++; $display("FAIL mid_readback: got %h need beef0011", rd); end
    endtask

    task automatic test_back_to_back();
        bit we_l[3]; logic [31:0] ad_l[3], d_l[3];
        int n; bit got;
        we_l = '{1'b1, 1'b0, 1'b1};
        ad_l = '{32'h18, 32'h18, 32'h1C};
        d_l  = '{$urandom, 32'h0, $urandom};
        for (int k = 0; k < 3; k++) begin
            req_valid[1] = 1'b1; req_we[1] = we_l[k];
            req_addr[63:32] = ad_l[k]; req_wdata[63:32] = d_l[k];
            n = 0; got = 0;
            while (!got && n < 60) begin @(negedge clk); n++; got = (ack != 2'b00); end
            if (!got) begin checks++; errors++; $display("FAIL b2b_timeout: no ack for command %0d", k); break; end
            $display("txn b2b%0d req1 %s addr=%h ack=%b rdata=%h spacing=%0d", k, we_l[k] ? "WR" : "RD", ad_l[k], ack, rsp_rdata, n);
            checks++; if (ack !== 2'b10) begin errors++; $display("FAIL b2b_ack%0d: got %b need 10", k, ack); end
            checks++; if (n !== ((k == 0) ? 3 : 4)) begin errors++; $display("FAIL b2b_spacing%0d: got %0d need %0d", k, n, (k == 0) ? 3 : 4); end
            if (we_l[k]) ref_mem[ad_l[k][5:2]] = d_l[k];
            else begin
                checks++; if (rsp_rdata !== ref_mem[ad_l[k][5:2]]) begin errors++; $display("FAIL b2b_rdata%0d: got %h need %h", k, rsp_rdata, ref_mem[ad_l[k][5:2]]); end
            end
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit pend[2]; bit pwe[2]; logic [31:0] pa[2], pd[2];
        int last, w, n; bit got; logic [1:0] exp_ack, exp_resp;
        apply_reset();
        last = 1; pend[0] = 0; pend[1] = 0;
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 3) != 0 || (r == 1 && !pend[0]))) begin
                    pend[r] = 1; pwe[r] = 1'($urandom_range(0, 1));
                    pa[r] = 32'($urandom_range(0, 15)) << 2; pd[r] = $urandom;
                end
                req_valid[r] = pend[r]; req_we[r] = pwe[r];
                req_addr[r*32 +: 32] = pa[r]; req_wdata[r*32 +: 32] = pd[r];
            end
            aw_stall = $urandom_range(0, 2); w_stall = $urandom_range(0, 2); ar_stall = $urandom_range(0, 2);
            b_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
            n = 0; got = 0;
            while (!got && n < 80) begin @(negedge clk); n++; got = (ack != 2'b00); end
            if (!got) begin checks++; errors++; $display("FAIL rnd_timeout: no ack at txn %0d", t); break; end
            w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
            exp_ack = 2'(1 << w);
            exp_resp = (!pwe[w] && pa[w] == 32'hC) ? 2'b10 : 2'b00;
            $display("txn rnd%0d req%0d %s addr=%h ack=%b resp=%b rdata=%h", t, w, pwe[w] ? "WR" : "RD", pa[w], ack, rsp_resp, rsp_rdata);
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rnd_ack%0d: got %b need %b", t, ack, exp_ack); end
            checks++; if (rsp_resp !== exp_resp) begin errors++; $display("FAIL rnd_resp%0d: got %b need %b", t, rsp_resp, exp_resp); end
            if (pwe[w]) ref_mem[pa[w][5:2]] = pd[w];
            else begin
                checks++; if (rsp_rdata !== ref_mem[pa[w][5:2]]) begin errors++; $display("FAIL rnd_rdata%0d: got %h need %h", t, rsp_rdata, ref_mem[pa[w][5:2]]); end
            end
            last = w; pend[w] = 0;
        end
        req_valid = 2'b00;
        aw_stall = 0; w_stall = 0; ar_stall = 0; b_delay = 0; r_delay = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        test_reset();
        test_basic();
        test_round_robin();
        test_aw_stall();
        test_read_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
